uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit framing controller.
//   Accepts parallel bytes from a host into a one-deep holding slot, then
//   frames each byte as start bit, data bits (taken from an external
//   serializer), optional parity bit and stop bit on TX_OUT.
//
// Ports:
//   CLK         in   clock, all logic on rising edge
//   RST         in   synchronous active-high reset
//   P_Data      in   parallel byte from host
//   Data_Valid  in   host write strobe
//   PAR_EN      in   1 = append parity bit (sampled with the byte)
//   PAR_TYP     in   0 = even, 1 = odd (sampled with the byte)
//   SER_Done    in   serializer: current SER_Data is the last data bit
//   SER_Data    in   serializer bit
//   SER_EN      out  serializer enable (high only in DATA)
//   SER_P_Data  out  active byte presented to the serializer
//   TX_OUT      out  serial line, idle high
//   Busy        out  frame in progress
//   Ready       out  holding slot can take a byte this cycle
//   Ser_Err     out  one-cycle pulse on serializer timeout abort
//
// State | meaning
// IDLE  | line high, waiting for the holding slot to fill
// START | start bit (one cycle)
// DATA  | serializer drives the line until SER_Done or timeout
// PARITY| parity bit (one cycle)
// STOP  | stop bit (one cycle), chains straight into START if a byte waits

module uart_tx_ctrl #(
  parameter int data_width = 8,
  parameter int timeout    = data_width + 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [data_width-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  SER_Done,
  input  logic                  SER_Data,
  output logic                  SER_EN,
  output logic [data_width-1:0] SER_P_Data,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Ready,
  output logic                  Ser_Err
);

  localparam int CW = (timeout < 2) ? 1 : $clog2(timeout);
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [data_width-1:0] act_data_q, act_data_d;
  logic                  act_par_en_q, act_par_en_d;
  logic                  act_par_q, act_par_d;
  logic                  hold_full_q, hold_full_d;
  logic [data_width-1:0] hold_data_q, hold_data_d;
  logic                  hold_par_en_q, hold_par_en_d;
  logic                  hold_par_q, hold_par_d;
  logic                  ser_err_q, ser_err_d;

  logic drain;
  logic accept;

  // The slot is emptied into the active register in IDLE and STOP; a write
  // in that same cycle refills it, so Ready stays high while draining.
  assign drain  = hold_full_q & ((state_q == S_IDLE) | (state_q == S_STOP));
  assign Ready  = ~hold_full_q | drain;
  assign accept = Data_Valid & Ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    act_data_d    = act_data_q;
    act_par_en_d  = act_par_en_q;
    act_par_d     = act_par_q;
    hold_full_d   = hold_full_q;
    hold_data_d   = hold_data_q;
    hold_par_en_d = hold_par_en_q;
    hold_par_d    = hold_par_q;
    ser_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) state_d = S_START;
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (SER_Done) begin
          state_d = act_par_en_q ? S_PARITY : S_STOP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Serializer never flagged the last bit: abort straight to STOP.
          ser_err_d = 1'b1;
          state_d   = S_STOP;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = hold_full_q ? S_START : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (drain) begin
      act_data_d   = hold_data_q;
      act_par_en_d = hold_par_en_q;
      act_par_d    = hold_par_q;
      hold_full_d  = 1'b0;
    end

    if (accept) begin
      hold_data_d   = P_Data;
      hold_par_en_d = PAR_EN;
      hold_par_d    = (^P_Data) ^ PAR_TYP;
      hold_full_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      act_data_q    <= '0;
      act_par_en_q  <= 1'b0;
      act_par_q     <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_par_en_q <= 1'b0;
      hold_par_q    <= 1'b0;
      ser_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_data_q    <= act_data_d;
      act_par_en_q  <= act_par_en_d;
      act_par_q     <= act_par_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      hold_par_en_q <= hold_par_en_d;
      hold_par_q    <= hold_par_d;
      ser_err_q     <= ser_err_d;
    end
  end

  // Line level is decoded from the state register; only DATA passes the
  // serializer bit through combinationally.
  always_comb begin
    TX_OUT = 1'b1;
    case (state_q)
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = SER_Data;
      S_PARITY: TX_OUT = act_par_q;
      default:  TX_OUT = 1'b1;
    endcase
  end

  assign SER_EN     = (state_q == S_DATA);
  assign Busy       = (state_q != S_IDLE);
  assign SER_P_Data = act_data_q;
  assign Ser_Err    = ser_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  localparam int DW      = 8;
  localparam int TIMEOUT = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_Data;
  logic          Data_Valid, PAR_EN, PAR_TYP;
  logic          SER_Done, SER_Data;
  logic          SER_EN, TX_OUT, Busy, Ready, Ser_Err;
  logic [DW-1:0] SER_P_Data;

  uart_tx_ctrl #(.data_width(DW)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .SER_Done(SER_Done), .SER_Data(SER_Data),
    .SER_EN(SER_EN), .SER_P_Data(SER_P_Data), .TX_OUT(TX_OUT), .Busy(Busy),
    .Ready(Ready), .Ser_Err(Ser_Err)
  );

  always #5 CLK = ~CLK;

  // Serializer model: LSB first, index cleared whenever SER_EN is low.
  logic [2:0] idx = '0;
  logic       no_done = 1'b0;
  always @(posedge CLK) idx <= SER_EN ? idx + 3'd1 : 3'd0;
  assign SER_Data = SER_P_Data[idx];
  assign SER_Done = SER_EN && (idx == 3'd7) && !no_done;

  typedef struct packed {
    logic tx;
    logic en;
    logic err;
    logic contig;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic push_bit(input logic tx, input logic en, input logic err, input logic contig);
    exp_t e;
    e.tx = tx; e.en = en; e.err = err; e.contig = contig;
    q.push_back(e);
  endtask

  // Expected line sequence for one frame, hand-derived from the framing rules.
  task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic contig, input logic to_mode);
    int n;
    push_bit(1'b0, 1'b0, 1'b0, contig);
    n = to_mode ? TIMEOUT : 8;
    for (int i = 0; i < n; i++) push_bit(d[i % 8], 1'b1, 1'b0, 1'b0);
    if (!to_mode && pen) push_bit((^d) ^ ptyp, 1'b0, 1'b0, 1'b0);
    push_bit(1'b1, 1'b0, to_mode, 1'b0);
  endtask

  // Monitor: pops one expectation per busy cycle; idle cycles must look idle.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      if (Busy) begin
        if (q.size() == 0) begin
          chk("unexpected_busy", {31'd0, Busy}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("line_tx_en_err", {29'd0, TX_OUT, SER_EN, Ser_Err}, {29'd0, e.tx, e.en, e.err});
          if (e.contig) chk("no_idle_gap", {31'd0, prev_busy}, 32'd1);
        end
      end else begin
        chk("idle_outputs", {29'd0, TX_OUT, SER_EN, Ser_Err}, {29'd0, 3'b100});
      end
    end
    prev_busy = Busy;
  end

  task automatic strobe(input logic [7:0] d, input logic pen, input logic ptyp);
    @(posedge CLK); #1;
    P_Data = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge CLK);
      if (!Busy && q.size() == 0) done = 1'b1;
    end
    chk("wait_idle", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    RST = 1'b1; P_Data = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tx",      {31'd0, TX_OUT},  32'd1);
    chk("rst_busy",    {31'd0, Busy},    32'd0);
    chk("rst_ser_en",  {31'd0, SER_EN},  32'd0);
    chk("rst_ready",   {31'd0, Ready},   32'd1);
    chk("rst_ser_err", {31'd0, Ser_Err}, 32'd0);
    chk("rst_p_data",  {24'd0, SER_P_Data}, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    mon_en = 1'b1;

    // A5, no parity: 0,1,0,1,0,0,1,0,1,1 over 10 busy cycles.
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    strobe(8'hA5, 1'b0, 1'b0);
    @(negedge CLK);
    chk("latency_busy_low",  {31'd0, Busy},  32'd0);
    chk("drain_ready_high",  {31'd0, Ready}, 32'd1);
    wait_idle(40);

    // 07 with even parity (bit 1), then odd parity (bit 0).
    push_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe(8'h07, 1'b1, 1'b0);
    wait_idle(40);
    push_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    strobe(8'h07, 1'b1, 1'b1);
    wait_idle(40);

    // Back-to-back 11, 22, and a third byte that must be dropped.
    push_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge CLK); #1;
    P_Data = 8'h11; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    chk("b2b_ready_first", {31'd0, Ready}, 32'd1);
    @(posedge CLK); #1;
    P_Data = 8'h22;
    @(negedge CLK);
    chk("b2b_ready_drain", {31'd0, Ready}, 32'd1);
    @(posedge CLK); #1;
    P_Data = 8'h33;
    @(negedge CLK);
    chk("b2b_ready_full", {31'd0, Ready}, 32'd0);
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    PAR_EN = 1'b1; PAR_TYP = 1'b1;   // must not affect queued frames
    repeat (3) @(negedge CLK);
    chk("b2b_ready_held", {31'd0, Ready}, 32'd0);
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    wait_idle(60);
    repeat (20) @(negedge CLK);
    chk("b2b_no_third_frame", {31'd0, Busy}, 32'd0);

    // Serializer stuck: 10 DATA cycles, error on the stop bit, parity skipped.
    no_done = 1'b1;
    push_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    strobe(8'h3C, 1'b1, 1'b0);
    wait_idle(60);
    no_done = 1'b0;

    // Reset during DATA with a second byte pending.
    mon_en = 1'b0;
    strobe(8'hF0, 1'b0, 1'b0);
    strobe(8'h0F, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (SER_EN) seen = 1'b1;
    end
    chk("rst_mid_reached_data", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge CLK);
    @(posedge CLK); #1;
    RST = 1'b1; Data_Valid = 1'b1; P_Data = 8'h99;
    @(posedge CLK); #1;
    RST = 1'b0; Data_Valid = 1'b0;
    @(negedge CLK);
    chk("mid_rst_tx",     {31'd0, TX_OUT}, 32'd1);
    chk("mid_rst_busy",   {31'd0, Busy},   32'd0);
    chk("mid_rst_ser_en", {31'd0, SER_EN}, 32'd0);
    chk("mid_rst_ready",  {31'd0, Ready},  32'd1);
    chk("mid_rst_p_data", {24'd0, SER_P_Data}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (Busy) seen = 1'b1;
    end
    chk("mid_rst_pending_dropped", {31'd0, seen}, 32'd0);
    q.delete();
    mon_en = 1'b1;

    // Recovery frame: 5A with odd parity (bit 1).
    push_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    strobe(8'h5A, 1'b1, 1'b1);
    wait_idle(40);
    repeat (3) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
